// File: rtl/cam_match_serializer.sv
// cam_match_serializer: walks a CAM match vector and emits every set bit's
// index in priority order, one index per valid/ready handshake.
module cam_match_serializer #(
  parameter int    WIDTH        = 32,
  parameter string LSB_PRIORITY = "LOW",
  localparam int   IW           = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_match_vector,
  input  logic             s_match_valid,
  output logic             s_match_ready,
  output logic [IW-1:0]    m_index,
  output logic             m_index_last,
  output logic             m_index_valid,
  input  logic             m_index_ready,
  output logic             miss,
  output logic             busy
);

  // "LOW" priority means the highest index wins, as in priority_encoder
  localparam bit MSB_FIRST = (LSB_PRIORITY == "LOW");

  typedef enum logic {
    IDLE,
    ITER
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] vec_q;
  logic [WIDTH-1:0] vec_d;
  logic             miss_q;
  logic             miss_d;
  logic [IW-1:0]    enc;
  logic             one_left;

  always_comb begin
    enc = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++)
        if (vec_q[i]) enc = IW'(i);
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--)
        if (vec_q[i]) enc = IW'(i);
    end
  end

  assign one_left = (vec_q != '0) &&
                    ((vec_q & (vec_q - WIDTH'(1))) == '0);

  always_comb begin
    state_d       = state_q;
    vec_d         = vec_q;
    miss_d        = 1'b0;
    s_match_ready = 1'b0;
    m_index_valid = 1'b0;
    busy          = 1'b0;
    unique case (state_q)
      IDLE: begin
        s_match_ready = 1'b1;
        if (s_match_valid) begin
          if (s_match_vector == '0) begin
            miss_d = 1'b1;
          end else begin
            vec_d   = s_match_vector;
            state_d = ITER;
          end
        end
      end
      ITER: begin
        busy          = 1'b1;
        m_index_valid = 1'b1;
        if (m_index_ready) begin
          vec_d = vec_q & ~(WIDTH'(1) << enc);
          if (one_left) state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      miss_q  <= miss_d;
    end
  end

  // vec_q is cleared in IDLE, so index/last read back as zero there
  assign m_index      = enc;
  assign m_index_last = one_left;
  assign miss         = miss_q;

endmodule
